game_core: RTL

- Sequential game engine for the cat/dog/mouse lane game.
- Produces the difficulty, game state and lane positions that the dot-matrix display stage consumes directly.
- Handles mouse control from buttons, pseudo-random cat/dog movement at a difficulty-dependent step rate, collision detection, and win/lose sequencing.
- Sits between the button front end (already debounced levels) and the display driver.

---
 rtl/game_core.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/game_core.sv
// game_core: sequential engine for the cat/dog/mouse lane game.
// Drives difficulty, game state, lane positions and step count for the display.
// Optional build macro: DOG_SHIELD_EN (a dog in the mouse lane blocks a cat hit).
module game_core #(
    parameter int         TICK_BASE = 25000000,
    parameter int         WIN_STEPS = 30,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw6,
    input  logic       sw5,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [1:0] gameDifficulty,
    output logic [1:0] gameState,
    output logic [1:0] cnt_cat,
    output logic [1:0] cnt_dog,
    output logic [1:0] cnt_mouse,
    output logic [5:0] steps
);
    localparam logic [1:0] S_LOSE  = 2'd0;
    localparam logic [1:0] S_WIN   = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_SETUP = 2'd3;

    localparam int            CW    = $clog2(TICK_BASE + 1);
    localparam logic [CW-1:0] TB    = CW'(TICK_BASE);
    localparam logic [5:0]    WIN_V = 6'(WIN_STEPS);

    logic [1:0]    r_state;
    logic [1:0]    r_diff;
    logic [1:0]    r_tdiff;
    logic [1:0]    r_cat;
    logic [1:0]    r_dog;
    logic [1:0]    r_mouse;
    logic [5:0]    r_steps;
    logic [CW-1:0] r_tcnt;
    logic [7:0]    r_lfsr;
    logic          r_left_q;
    logic          r_right_q;

    logic          w_le;
    logic          w_re;
    logic          w_hit;
    logic          w_tick;
    logic [CW-1:0] w_period;

    assign w_le     = btn_left & ~r_left_q;
    assign w_re     = btn_right & ~r_right_q;
    // Period is fixed by the difficulty captured at PLAY entry.
    assign w_period = TB >> r_tdiff;
    assign w_tick   = (w_period <= CW'(1)) || (r_tcnt >= w_period - CW'(1));

`ifdef DOG_SHIELD_EN
    assign w_hit = (r_cat == r_mouse) && (r_dog != r_mouse);
`else
    assign w_hit = (r_cat == r_mouse);
`endif

    // Registered copies of the button levels for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_left_q  <= 1'b0;
            r_right_q <= 1'b0;
        end else begin
            r_left_q  <= btn_left;
            r_right_q <= btn_right;
        end
    end

    // Free-running Fibonacci LFSR, taps 8,6,5,4; a non-zero seed keeps it non-zero.
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    // Game FSM: difficulty select, mouse moves, tick-driven cat/dog, win/lose.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_SETUP;
            r_diff  <= 2'd0;
            r_tdiff <= 2'd0;
            r_mouse <= 2'd0;
            r_cat   <= 2'd2;
            r_dog   <= 2'd1;
            r_steps <= 6'd0;
            r_tcnt  <= '0;
        end else if (!sw6) begin
            r_state <= S_SETUP;
            r_mouse <= 2'd0;
            r_cat   <= 2'd2;
            r_dog   <= 2'd1;
            r_steps <= 6'd0;
            r_tcnt  <= '0;
        end else begin
            case (r_state)
                S_SETUP: begin
                    r_mouse <= 2'd0;
                    r_cat   <= 2'd2;
                    r_dog   <= 2'd1;
                    r_steps <= 6'd0;
                    if (sw5) begin
                        if (w_re && !w_le)      r_diff <= r_diff + 2'd1;
                        else if (w_le && !w_re) r_diff <= r_diff - 2'd1;
                    end else begin
                        r_state <= S_PLAY;
                        r_tdiff <= r_diff;
                        r_tcnt  <= '0;
                    end
                end
                S_PLAY: begin
                    if (sw5) begin
                        r_state <= S_SETUP;
                        r_mouse <= 2'd0;
                        r_cat   <= 2'd2;
                        r_dog   <= 2'd1;
                        r_steps <= 6'd0;
                    end else if (w_hit) begin
                        // Positions freeze on the colliding configuration.
                        r_state <= S_LOSE;
                    end else if (r_steps == WIN_V) begin
                        r_state <= S_WIN;
                    end else begin
                        if (w_re && !w_le && r_mouse != 2'd3)      r_mouse <= r_mouse + 2'd1;
                        else if (w_le && !w_re && r_mouse != 2'd0) r_mouse <= r_mouse - 2'd1;
                        if (w_tick) begin
                            r_cat   <= r_lfsr[1:0];
                            r_dog   <= r_lfsr[3:2];
                            r_steps <= r_steps + 6'd1;
                            r_tcnt  <= '0;
                        end else begin
                            r_tcnt  <= r_tcnt + CW'(1);
                        end
                    end
                end
                default: begin
                    // WIN / LOSE: everything frozen until the player leaves.
                    if (sw5) begin
                        r_state <= S_SETUP;
                        r_mouse <= 2'd0;
                        r_cat   <= 2'd2;
                        r_dog   <= 2'd1;
                        r_steps <= 6'd0;
                    end
                end
            endcase
        end
    end

    assign gameDifficulty = r_diff;
    assign gameState      = r_state;
    assign cnt_cat        = r_cat;
    assign cnt_dog        = r_dog;
    assign cnt_mouse      = r_mouse;
    assign steps          = r_steps;
endmodule
